// File: rtl/QuplsPkg.sv
// Purpose: types and widths for the Qupls register-list sequencer.
// Contents: sequencer FSM state enum, 32-bit register-list mask type, field widths.
package QuplsPkg;

  localparam int unsigned REGLIST_W = 32;
  localparam int unsigned REGIDX_W  = 5;
  localparam int unsigned OFFSET_W  = 16;
  localparam int unsigned SCALE_W   = 3;

  typedef logic [REGLIST_W-1:0] reglist_mask_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } reglist_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Purpose: shared CPU-wide types used by the Qupls front end.
// Contents: architectural register number width and type.
package cpu_types_pkg;

  localparam int unsigned AREGNO_W = 7;

  typedef logic [AREGNO_W-1:0] aregno_t;

endpackage

// File: rtl/qupls_ffz32_lo.sv
// Purpose: combinational finder for the lowest set bit of a 32-bit vector.
// Ports: vec   - input vector
//        idx   - index of the lowest set bit (0 when none)
//        found - high when any bit of vec is set
module qupls_ffz32_lo
  import QuplsPkg::*;
(
  input  logic [REGLIST_W-1:0] vec,
  output logic [REGIDX_W-1:0]  idx,
  output logic                 found
);

  // Scan high to low so the lowest set bit is the last one to write idx.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = REGLIST_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = REGIDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qupls_reglist_seq.sv
// Purpose: sequences a register-list instruction into one element per enabled
//          cycle, in ascending register order, with per-element memory offset.
// Ports: clk, rst (async active-high)
//        en            - advance; everything holds when low
//        flush         - abort to idle, no done pulse
//        start, mask   - instruction offer and register bit list
//        scale_regs_i  - log2 bytes per element, captured at start
//        busy, stall   - sequence running / hold upstream instruction
//        reglist_active, regcnt, offset, ls_bmf, last - current element
//        done          - one-cycle completion pulse
// Config: QUPLS_REGLIST_PACK_EN defined -> offsets from element count (packed);
//         undefined -> offsets from register number (sparse).
module qupls_reglist_seq
  import QuplsPkg::*;
  import cpu_types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  input  logic                start,
  input  logic [31:0]         mask,
  input  logic [2:0]          scale_regs_i,
  output logic                busy,
  output logic                stall,
  output logic                reglist_active,
  output aregno_t             regcnt,
  output logic [15:0]         offset,
  output logic                ls_bmf,
  output logic                last,
  output logic                done
);

  reglist_state_t        state_q, state_d;
  reglist_mask_t         work_q, work_d;
  logic [SCALE_W-1:0]    scale_q, scale_d;

  reglist_mask_t         src;
  reglist_mask_t         rest;
  logic [REGIDX_W-1:0]   idx;
  logic                  found;
  logic [SCALE_W-1:0]    sc;
  logic [REGIDX_W-1:0]   ord;
  logic [OFFSET_W-1:0]   elem_off;

  logic                  busy_d, stall_d, active_d, ls_bmf_d, last_d, done_d;
  aregno_t               regcnt_d;
  logic [OFFSET_W-1:0]   offset_d;

  // In idle the incoming mask is examined directly so the first element
  // can be registered on the accepting edge.
  assign src  = (state_q == IDLE) ? mask : work_q;
  assign rest = src & (src - reglist_mask_t'(1));
  assign sc   = (state_q == IDLE) ? scale_regs_i : scale_q;

  qupls_ffz32_lo u_ffz (
    .vec   (src),
    .idx   (idx),
    .found (found)
  );

`ifdef QUPLS_REGLIST_PACK_EN
  // Count of elements already emitted in this sequence.
  logic [REGIDX_W-1:0] cnt_q, cnt_d;
  assign ord = (state_q == IDLE) ? '0 : cnt_q;
`else
  assign ord = idx;
`endif

  assign elem_off = OFFSET_W'(ord) << sc;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    scale_d  = scale_q;
    busy_d   = busy;
    stall_d  = stall;
    active_d = reglist_active;
    regcnt_d = regcnt;
    offset_d = offset;
    ls_bmf_d = ls_bmf;
    last_d   = last;
    done_d   = done;
`ifdef QUPLS_REGLIST_PACK_EN
    cnt_d    = cnt_q;
`endif

    if (flush) begin
      state_d  = IDLE;
      work_d   = '0;
      busy_d   = 1'b0;
      stall_d  = 1'b0;
      active_d = 1'b0;
      regcnt_d = '0;
      offset_d = '0;
      ls_bmf_d = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;
`ifdef QUPLS_REGLIST_PACK_EN
      cnt_d    = '0;
`endif
    end else if (en) begin
      done_d = 1'b0;
      if ((state_q == IDLE && start) || state_q == RUN) begin
        if (found) begin
          // Present the lowest remaining register and retire its bit.
          state_d  = RUN;
          work_d   = rest;
          busy_d   = 1'b1;
          active_d = 1'b1;
          regcnt_d = aregno_t'(idx);
          offset_d = elem_off;
          ls_bmf_d = (state_q == IDLE);
          last_d   = (rest == '0);
          stall_d  = (rest != '0);
          if (state_q == IDLE) begin
            scale_d = scale_regs_i;
          end
`ifdef QUPLS_REGLIST_PACK_EN
          cnt_d    = (state_q == IDLE) ? REGIDX_W'(1) : cnt_q + REGIDX_W'(1);
`endif
        end else begin
          // Empty list offered, or the last element has been presented.
          state_d  = IDLE;
          work_d   = '0;
          busy_d   = 1'b0;
          stall_d  = 1'b0;
          active_d = 1'b0;
          regcnt_d = '0;
          offset_d = '0;
          ls_bmf_d = 1'b0;
          last_d   = 1'b0;
          done_d   = 1'b1;
`ifdef QUPLS_REGLIST_PACK_EN
          cnt_d    = '0;
`endif
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      work_q         <= '0;
      scale_q        <= '0;
      busy           <= 1'b0;
      stall          <= 1'b0;
      reglist_active <= 1'b0;
      regcnt         <= '0;
      offset         <= '0;
      ls_bmf         <= 1'b0;
      last           <= 1'b0;
      done           <= 1'b0;
`ifdef QUPLS_REGLIST_PACK_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      scale_q        <= scale_d;
      busy           <= busy_d;
      stall          <= stall_d;
      reglist_active <= active_d;
      regcnt         <= regcnt_d;
      offset         <= offset_d;
      ls_bmf         <= ls_bmf_d;
      last           <= last_d;
      done           <= done_d;
`ifdef QUPLS_REGLIST_PACK_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_qupls_reglist_seq.sv
// Purpose: self-checking bench for qupls_reglist_seq. A list-based model turns
//          each mask into the expected per-cycle output trace; en, trailing
//          starts, flush and reset are applied around it.
module tb_qupls_reglist_seq;
  import cpu_types_pkg::*;

  localparam int unsigned AW = $bits(aregno_t);
  localparam int unsigned OW = 3 + AW + 16 + 3;
  typedef logic [OW-1:0] obs_t;

  logic        clk = 1'b0;
  logic        rst, en, flush, start;
  logic [31:0] mask;
  logic [2:0]  scale;
  logic        busy, stall, reglist_active, ls_bmf, last, done;
  aregno_t     regcnt;
  logic [15:0] offset;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t trace[$];
  int   trace_n;

  always #5 clk = ~clk;

  qupls_reglist_seq dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .flush          (flush),
    .start          (start),
    .mask           (mask),
    .scale_regs_i   (scale),
    .busy           (busy),
    .stall          (stall),
    .reglist_active (reglist_active),
    .regcnt         (regcnt),
    .offset         (offset),
    .ls_bmf         (ls_bmf),
    .last           (last),
    .done           (done)
  );

  function automatic obs_t pack(input logic b, input logic st, input logic a,
                                input int r, input int o, input logic l,
                                input logic la, input logic d);
    return {b, st, a, AW'(r), 16'(o), l, la, d};
  endfunction

  function automatic obs_t observed();
    return {busy, stall, reglist_active, regcnt, offset, ls_bmf, last, done};
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t obs;
    obs = observed();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected trace: one entry per element, then the done cycle, then idle.
  task automatic build(input logic [31:0] m, input int s);
    int k, n, ord;
    trace.delete();
    n = $countones(m);
    k = 0;
    for (int r = 0; r < 32; r++) begin
      if (m[r]) begin
`ifdef QUPLS_REGLIST_PACK_EN
        ord = k;
`else
        ord = r;
`endif
        trace.push_back(pack(1'b1, k != n - 1, 1'b1, r, (ord * (1 << s)) % 65536,
                             k == 0, k == n - 1, 1'b0));
        k++;
      end
    end
    trace.push_back(pack(0, 0, 0, 0, 0, 0, 0, 1));
    trace.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0));
    trace_n = n;
  endtask

  // Called at a negedge. mode 0: en high; 1: random en; 2: en low 2 cycles
  // after the first element. Extra starts are offered while the sequence runs.
  task automatic run_seq(input logic [31:0] m, input int s, input int mode,
                         input string tag);
    int pos, cyc;
    build(m, s);
    start = 1'b1; mask = m; scale = 3'(s); en = 1'b1; flush = 1'b0;
    pos = 0; cyc = 0;
    while (pos < trace.size()) begin
      @(negedge clk);
      cyc++;
      check(tag, trace[pos]);
      mask  = $urandom;
      scale = 3'($urandom_range(0, 7));
      start = (pos < trace_n);
      case (mode)
        1:       en = ($urandom_range(0, 3) != 0);
        2:       en = !(cyc == 1 || cyc == 2);
        default: en = 1'b1;
      endcase
      if (en) pos++;
      if (cyc > 400) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s_budget observed=%0d expected<=%0d", tag, cyc, 400);
        break;
      end
    end
    start = 1'b0;
    en    = 1'b1;
  endtask

  obs_t zero;

  initial begin
    zero  = pack(0, 0, 0, 0, 0, 0, 0, 0);
    rst   = 1'b1;
    en    = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    mask  = '0;
    scale = '0;
    repeat (2) @(negedge clk);
    check("reset", zero);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    check("idle", zero);

    run_seq(32'h0000_0015, 3, 0, "seq15");
    run_seq(32'h0000_0000, 1, 0, "zero_mask");
    run_seq(32'h8000_0001, 0, 2, "freeze");
    run_seq(32'h8000_0000, 7, 0, "bit31");
    run_seq(32'hFFFF_FFFF, 7, 1, "all32");
    run_seq(32'h0000_0001, 2, 1, "single");

    // Flush on the second element, then an immediate new start.
    build(32'h0000_00FF, 2);
    start = 1'b1; mask = 32'h0000_00FF; scale = 3'd2; en = 1'b1;
    @(negedge clk);
    check("flush_e0", trace[0]);
    start = 1'b0;
    @(negedge clk);
    check("flush_e1", trace[1]);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", zero);
    run_seq(32'h0000_0120, 4, 0, "after_flush");

    // Flush beats start in idle.
    flush = 1'b1; start = 1'b1; mask = 32'h0000_0003;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_prio", zero);
    @(negedge clk);
    check("flush_prio2", zero);

    // Asynchronous reset mid-sequence.
    build(32'h0000_00F0, 1);
    start = 1'b1; mask = 32'h0000_00F0; scale = 3'd1;
    @(negedge clk);
    check("rst_e0", trace[0]);
    start = 1'b0;
    @(negedge clk);
    check("rst_e1", trace[1]);
    #2 rst = 1'b1;
    #1 check("rst_async", zero);
    @(negedge clk);
    rst = 1'b0;
    check("rst_held", zero);
    @(negedge clk);
    check("rst_nodone", zero);
    @(negedge clk);
    check("rst_nodone2", zero);

    for (int t = 0; t < 8; t++) begin
      run_seq($urandom & $urandom, $urandom_range(0, 7), 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qupls_reglist_seq.md
QUPLS_REGLIST_SEQ -- requirements
Module: qupls_reglist_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: en  in  1  pipeline advance; nothing changes when low. flush  in  1  abort sequence.
REQ-003 SHALL have ports: start  in  1  register-list instruction offered; mask  in  32  register bit list, bit i selects register i.
REQ-004 SHALL have ports: scale_regs_i  in  3  offset scale, log2 bytes per element.
REQ-005 SHALL have ports: busy  out  1  sequence in progress; stall  out  1  hold fetch/extract.
REQ-006 SHALL have ports: reglist_active  out  1  element valid this cycle; regcnt  out  cpu_types_pkg::aregno_t  register number of element.
REQ-007 SHALL have ports: offset  out  16  memory offset of element; ls_bmf  out  1  first element; last  out  1  final element; done  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement a two-state FSM: IDLE, RUN.
REQ-009 IDLE with en and start and mask non-zero SHALL latch mask into a working register and enter RUN; first element is presented the next cycle.
REQ-010 IDLE with en and start and mask zero SHALL stay in IDLE and pulse done the next cycle, with reglist_active low.
REQ-011 In RUN, each en cycle SHALL present the lowest set bit index of the working mask on regcnt, zero-extended, then clear that bit.
REQ-012 Elements SHALL be emitted in ascending register order, one per en cycle; en low freezes all state and outputs.
REQ-013 ls_bmf SHALL be high only with the first element; last SHALL be high when the presented element is the only remaining bit.
REQ-014 After the element flagged last, the FSM SHALL return to IDLE and done SHALL pulse for one cycle.
REQ-015 Single-bit mask: ls_bmf and last SHALL both be high on the same element.
REQ-016 stall SHALL be high in RUN whenever more than one bit remains, including the cycle start is accepted, so the upstream mux holds the instruction.
REQ-017 A start arriving while busy SHALL be ignored.
REQ-018 flush SHALL force IDLE next edge, clear the working mask, and drop reglist_active and stall without pulsing done; flush has priority over start.
REQ-019 offset SHALL equal element ordinal shifted left by scale_regs_i, truncated to 16 bits; scale_regs_i is sampled at start and held for the sequence.
REQ-020 Maximum sequence length SHALL be 32 elements; mask bit 31 SHALL emit regcnt=31 without wrap.

Reset
REQ-021 On rst, asynchronously: state IDLE, working mask 0, ordinal 0. All outputs SHALL be 0: busy, stall, reglist_active, regcnt, offset, ls_bmf, last, done.
REQ-022 Reset mid-sequence SHALL abandon the sequence with no done pulse.

Configuration
REQ-023 Macro QUPLS_REGLIST_PACK_EN defined: the ordinal is the count of elements already emitted (packed offsets 0,1,2..).
REQ-024 QUPLS_REGLIST_PACK_EN undefined: the ordinal is the register number itself (sparse offsets); all other behaviour is identical.

Structure
REQ-025 The FSM state enum and the 32-bit reglist mask typedef SHALL live in QuplsPkg; aregno_t SHALL come from cpu_types_pkg.
REQ-026 The lowest-set-bit finder SHALL be a separate combinational sub-module, qupls_ffz32_lo, returning index and a found flag.

Verification
REQ-027 mask=32'h0000_0015, scale=3, en held high -> regcnt 0,2,4 on consecutive cycles; packed offsets 0,8,16; ls_bmf on element 1; last on element 3; then done.
REQ-028 Same stimulus without QUPLS_REGLIST_PACK_EN -> offsets 0,16,32.
REQ-029 mask=0 with start -> done pulses the next cycle; reglist_active never high; stall never high.
REQ-030 mask=32'h8000_0001 with en toggled low for 2 cycles mid-sequence -> outputs frozen while en low; sequence resumes with regcnt=31 carrying last.
REQ-031 flush on second element of mask=32'hFF -> IDLE next cycle, stall low, no done; a new start the following cycle is accepted.
REQ-032 rst asserted asynchronously mid-sequence -> all outputs 0 before the next clk edge; start with a second start while busy -> the second is ignored.
